// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the shared-memory fill arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        TGT_I = 1'b0,
        TGT_D = 1'b1
    } fill_tgt_t;

    localparam int          BLK_WORDS_DEF = 8;
    // Byte-offset bits inside one block of 16-bit words
    localparam logic [15:0] BLK_OFF_MASK  = 16'(BLK_WORDS_DEF * 2 - 1);

endpackage

// File: rtl/mem_fill_arbiter.sv
// Arbiter/sequencer for the main memory shared by the I-cache and D-cache.
// Build option MEM_ARB_RR_EN adds a one-shot starvation guard for i_miss.
module mem_fill_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int BLK_WORDS = BLK_WORDS_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_miss,
    input  logic [ADDR_W-1:0]            i_miss_addr,
    input  logic                         d_miss,
    input  logic [ADDR_W-1:0]            d_miss_addr,
    input  logic                         d_wr,
    input  logic [ADDR_W-1:0]            d_wr_addr,
    input  logic [DATA_W-1:0]            d_wr_data,
    output logic                         mem_en,
    output logic                         mem_wr,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic                         mem_rvalid,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic                         fill_we,
    output logic                         fill_tgt,
    output logic [$clog2(BLK_WORDS)-1:0] fill_idx,
    output logic [DATA_W-1:0]            fill_data,
    output logic                         i_fill_done,
    output logic                         d_fill_done,
    output logic                         d_wr_done,
    output logic                         i_busy,
    output logic                         d_busy
);

    localparam int                IDX_W    = $clog2(BLK_WORDS);
    localparam int                CNT_W    = IDX_W + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLK_WORDS - 1);
    localparam logic [CNT_W-1:0]  CNT_END  = CNT_W'(BLK_WORDS);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BLK_WORDS * 2 - 1);

    arb_state_t        state_r, state_s;
    fill_tgt_t         tgt_r;
    logic [ADDR_W-1:0] base_r;
    logic [DATA_W-1:0] wdata_r;
    logic [CNT_W-1:0]  issue_cnt_r;
    logic [CNT_W-1:0]  recv_cnt_r;
    logic              grant_wr_s, grant_d_s, grant_i_s;
    logic              issuing_s;
    logic              rr_flag_s;

`ifdef MEM_ARB_RR_EN
    logic rr_flag_r;

    // One-shot flag: i_miss was held while a D request won arbitration
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_flag_r <= 1'b0;
        end else if (grant_i_s) begin
            rr_flag_r <= 1'b0;
        end else if ((grant_wr_s || grant_d_s) && i_miss) begin
            rr_flag_r <= 1'b1;
        end
    end

    assign rr_flag_s = rr_flag_r;
`else
    assign rr_flag_s = 1'b0;
`endif

    // Arbitration and next-state selection
    always_comb begin
        state_s    = state_r;
        grant_wr_s = 1'b0;
        grant_d_s  = 1'b0;
        grant_i_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rr_flag_s && i_miss) begin
                    grant_i_s = 1'b1;
                    state_s   = ST_FILL;
                end else if (d_wr) begin
                    grant_wr_s = 1'b1;
                    state_s    = ST_WRITE;
                end else if (d_miss) begin
                    grant_d_s = 1'b1;
                    state_s   = ST_FILL;
                end else if (i_miss) begin
                    grant_i_s = 1'b1;
                    state_s   = ST_FILL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WRITE: state_s = ST_IDLE;
            ST_FILL: begin
                // Exit is driven purely by returned valids, never by cycle count
                if (mem_rvalid && (recv_cnt_r == CNT_LAST)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register, grant latches and issue/receive counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            tgt_r       <= TGT_I;
            base_r      <= '0;
            wdata_r     <= '0;
            issue_cnt_r <= '0;
            recv_cnt_r  <= '0;
        end else begin
            state_r <= state_s;
            if (grant_wr_s) begin
                tgt_r   <= TGT_D;
                base_r  <= d_wr_addr;
                wdata_r <= d_wr_data;
            end else if (grant_d_s) begin
                tgt_r  <= TGT_D;
                base_r <= d_miss_addr & ~OFF_MASK;
            end else if (grant_i_s) begin
                tgt_r  <= TGT_I;
                base_r <= i_miss_addr & ~OFF_MASK;
            end
            if (state_r == ST_IDLE) begin
                issue_cnt_r <= '0;
                recv_cnt_r  <= '0;
            end else if (state_r == ST_FILL) begin
                if (issuing_s) begin
                    issue_cnt_r <= issue_cnt_r + CNT_W'(1);
                end
                if (mem_rvalid && (recv_cnt_r < CNT_END)) begin
                    recv_cnt_r <= recv_cnt_r + CNT_W'(1);
                end
            end
        end
    end

    assign issuing_s = (state_r == ST_FILL) && (issue_cnt_r < CNT_END);

    // Output decode; idle fields are held at zero
    always_comb begin
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        fill_we     = 1'b0;
        fill_tgt    = 1'b0;
        fill_idx    = '0;
        fill_data   = '0;
        i_fill_done = 1'b0;
        d_fill_done = 1'b0;
        d_wr_done   = 1'b0;
        if (state_r == ST_WRITE) begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = base_r;
            mem_wdata = wdata_r;
            d_wr_done = 1'b1;
        end else if (issuing_s) begin
            mem_en   = 1'b1;
            mem_addr = base_r + (ADDR_W'(issue_cnt_r) << 1);
        end else begin
            mem_en = 1'b0;
        end
        if ((state_r == ST_FILL) && mem_rvalid) begin
            fill_we   = 1'b1;
            fill_tgt  = tgt_r;
            fill_idx  = recv_cnt_r[IDX_W-1:0];
            fill_data = mem_rdata;
        end else begin
            fill_we = 1'b0;
        end
        if (state_r == ST_DONE) begin
            i_fill_done = (tgt_r == TGT_I);
            d_fill_done = (tgt_r == TGT_D);
        end else begin
            i_fill_done = 1'b0;
        end
    end

    assign i_busy = i_miss | ((state_r != ST_IDLE) && (tgt_r == TGT_I));
    assign d_busy = d_miss | d_wr | ((state_r != ST_IDLE) && (tgt_r == TGT_D));

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Randomized bench for mem_fill_arbiter: a transaction-level timeline model
// predicts every output per cycle; a fixed-latency memory answers reads.
module tb_mem_fill_arbiter;

    localparam int MAXC = 128;
    localparam int BW   = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_miss, d_miss, d_wr;
    logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
    logic        mem_en, mem_wr, mem_rvalid;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        fill_we, fill_tgt;
    logic [2:0]  fill_idx;
    logic [15:0] fill_data;
    logic        i_fill_done, d_fill_done, d_wr_done, i_busy, d_busy;

    always #5 clk = ~clk;

    mem_fill_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .d_wr(d_wr), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .fill_we(fill_we), .fill_tgt(fill_tgt), .fill_idx(fill_idx), .fill_data(fill_data),
        .i_fill_done(i_fill_done), .d_fill_done(d_fill_done), .d_wr_done(d_wr_done),
        .i_busy(i_busy), .d_busy(d_busy)
    );

`ifdef MEM_ARB_RR_EN
    bit rr_en = 1'b1;
`else
    bit rr_en = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] salt = 16'h5A3C;

    logic        e_men   [0:MAXC-1];
    logic        e_mwr   [0:MAXC-1];
    logic [15:0] e_maddr [0:MAXC-1];
    logic [15:0] e_mwd   [0:MAXC-1];
    logic        e_fwe   [0:MAXC-1];
    logic        e_ftgt  [0:MAXC-1];
    logic [2:0]  e_fidx  [0:MAXC-1];
    logic [15:0] e_fdata [0:MAXC-1];
    logic [4:0]  e_ctl   [0:MAXC-1];
    bit          in_fill [0:MAXC-1];
    bit          pipe_v  [0:MAXC-1];
    logic [15:0] pipe_a  [0:MAXC-1];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ salt;
    endfunction

    // Requests are raised together at cycle 0; each is held until its own done.
    // n_d > 1 keeps d_miss held across blocks so it is re-requested.
    task automatic run_scn(input bit want_wr, input int n_d, input bit want_i,
                           input logic [15:0] wr_a, input logic [15:0] wr_d,
                           input logic [15:0] d_a, input logic [15:0] i_a,
                           input int lat, input int rst_cyc);
        int t, s, len, g, dn, wr_left, d_left, i_left;
        int wr_done_c, d_last, i_done_c, d_end;
        bit flag;
        logic [15:0] base, a;
        for (int k = 0; k < MAXC; k++) begin
            e_men[k] = 1'b0; e_mwr[k] = 1'b0; e_maddr[k] = 16'h0; e_mwd[k] = 16'h0;
            e_fwe[k] = 1'b0; e_ftgt[k] = 1'b0; e_fidx[k] = 3'd0; e_fdata[k] = 16'h0;
            e_ctl[k] = 5'd0; in_fill[k] = 1'b0; pipe_v[k] = 1'b0; pipe_a[k] = 16'h0;
        end
        wr_left = want_wr ? 1 : 0; d_left = n_d; i_left = want_i ? 1 : 0;
        wr_done_c = -1; d_last = -1; i_done_c = -1; flag = 1'b0; t = 0;
        while (wr_left + d_left + i_left > 0) begin
            if (rr_en && flag && i_left > 0) g = 2;
            else if (wr_left > 0)            g = 0;
            else if (d_left > 0)             g = 1;
            else                             g = 2;
            if (g == 2) flag = 1'b0;
            else if (i_left > 0) flag = 1'b1;
            s = t + 1;
            if (g == 0) begin
                e_men[s] = 1'b1; e_mwr[s] = 1'b1; e_maddr[s] = wr_a; e_mwd[s] = wr_d;
                e_ctl[s][2] = 1'b1;
                wr_done_c = s; wr_left = 0; t = s + 1;
            end else begin
                base = ((g == 1) ? d_a : i_a) & ~16'h000F;
                for (int j = 0; j < BW; j++) begin
                    a = base + 16'(2 * j);
                    e_men[s+j] = 1'b1; e_maddr[s+j] = a;
                    e_fwe[s+lat+j] = 1'b1; e_ftgt[s+lat+j] = (g == 1);
                    e_fidx[s+lat+j] = 3'(j); e_fdata[s+lat+j] = mem_word(a);
                end
                for (int k = s; k < s + lat + BW; k++) in_fill[k] = 1'b1;
                dn = s + lat + BW;
                if (g == 1) begin e_ctl[dn][3] = 1'b1; d_left--; d_last = dn; end
                else begin e_ctl[dn][4] = 1'b1; i_left = 0; i_done_c = dn; end
                t = dn + 1;
            end
        end
        len = t + 2;
        d_end = (wr_done_c > d_last) ? wr_done_c : d_last;
        for (int k = 0; k < len; k++) begin
            e_ctl[k][1] = (k <= i_done_c);
            e_ctl[k][0] = (k <= d_end);
        end
        if (rst_cyc >= 0) begin
            for (int k = rst_cyc + 1; k < MAXC; k++) begin
                e_men[k] = 1'b0; e_mwr[k] = 1'b0; e_maddr[k] = 16'h0; e_mwd[k] = 16'h0;
                e_fwe[k] = 1'b0; e_ftgt[k] = 1'b0; e_fidx[k] = 3'd0; e_fdata[k] = 16'h0;
                e_ctl[k] = 5'd0; in_fill[k] = 1'b0;
            end
            len = rst_cyc + lat + 4;
        end
        for (int k = 0; k < len; k++) begin
            @(posedge clk); #1;
            rst_n       = (k != rst_cyc);
            i_miss      = want_i && (k <= i_done_c) && (rst_cyc < 0 || k < rst_cyc);
            d_miss      = (n_d > 0) && (k <= d_last) && (rst_cyc < 0 || k < rst_cyc);
            d_wr        = want_wr && (k <= wr_done_c) && (rst_cyc < 0 || k < rst_cyc);
            i_miss_addr = i_a; d_miss_addr = d_a; d_wr_addr = wr_a; d_wr_data = wr_d;
            if (pipe_v[k]) begin
                mem_rvalid = 1'b1; mem_rdata = mem_word(pipe_a[k]);
            end else if (!in_fill[k] && $urandom_range(3) == 0) begin
                mem_rvalid = 1'b1; mem_rdata = 16'($urandom);
            end else begin
                mem_rvalid = 1'b0; mem_rdata = 16'($urandom);
            end
            #2;
            check_val($sformatf("mem c%0d", k), {mem_en, mem_wr, mem_addr, mem_wdata},
                      {e_men[k], e_mwr[k], e_maddr[k], e_mwd[k]});
            check_val($sformatf("fill c%0d", k), {fill_we, fill_tgt, fill_idx, fill_data},
                      {e_fwe[k], e_ftgt[k], e_fidx[k], e_fdata[k]});
            check_val($sformatf("done/busy c%0d", k),
                      {i_fill_done, d_fill_done, d_wr_done, i_busy, d_busy}, e_ctl[k]);
            if (mem_en && !mem_wr && (k + lat < MAXC)) begin
                pipe_v[k+lat] = 1'b1; pipe_a[k+lat] = mem_addr;
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; i_miss = 1'b0; d_miss = 1'b0; d_wr = 1'b0;
        i_miss_addr = 16'h0; d_miss_addr = 16'h0; d_wr_addr = 16'h0; d_wr_data = 16'h0;
        mem_rvalid = 1'b0; mem_rdata = 16'h0;
        repeat (3) @(posedge clk);
        #1 mem_rvalid = 1'b1; mem_rdata = 16'hFFFF;
        #2;
        check_val("reset mem", {mem_en, mem_wr, mem_addr, mem_wdata}, 64'd0);
        check_val("reset fill", {fill_we, fill_tgt, fill_idx, fill_data}, 64'd0);
        check_val("reset done/busy", {i_fill_done, d_fill_done, d_wr_done, i_busy, d_busy}, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1; mem_rvalid = 1'b0;

        run_scn(1'b0, 0, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0124, 4, -1);
        run_scn(1'b0, 1, 1'b1, 16'h0, 16'h0, 16'h2008, 16'h0040, 4, -1);
        run_scn(1'b1, 0, 1'b1, 16'h3002, 16'hBEEF, 16'h0, 16'h0040, 4, -1);
        run_scn(1'b0, 0, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0124, 4, 7);
        run_scn(1'b0, 0, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0124, 4, -1);
        run_scn(1'b0, 2, 1'b1, 16'h0, 16'h0, 16'h2008, 16'h0040, 3, -1);
        run_scn(1'b1, 1, 1'b1, 16'h1234, 16'h5678, 16'h4441, 16'h8882, 2, -1);

        for (int r = 0; r < 30; r++) begin
            bit w, i;
            int nd;
            salt = 16'($urandom);
            w  = 1'($urandom_range(1));
            nd = $urandom_range(2);
            i  = 1'($urandom_range(1));
            if (!w && nd == 0 && !i) i = 1'b1;
            run_scn(w, nd, i, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    $urandom_range(6, 1), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
